alu_operand_sequencer: RTL and testbench

// - Upstream/downstream wrapper around the combinational N-bit ALU units (bitwise AND/OR/XOR, adder).
// - Accepts an operation request over a valid/ready handshake and registers the operands and opcode.
// - Drives the ALU inputs for one settle cycle, then captures result and flags.
// - Presents the captured result over a valid/ready output handshake.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_flag_gen.sv | 20 ++
 rtl/alu_operand_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_operand_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode values and sequencer state encoding for the ALU operand sequencer.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation: zero detect on the ALU result and carry
// passed through only for the ADD opcode.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] Alu_Result,
    input  logic             Alu_Carry,
    input  logic [1:0]       Op_Sel,
    output logic             Zero,
    output logic             Carry
);

    always_comb begin
        Zero  = ~|Alu_Result;
        Carry = (Op_Sel == OP_ADD) ? Alu_Carry : 1'b0;
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Valid/ready wrapper around an external combinational ALU: registers a request,
// gives the ALU one settle cycle, captures result and flags, holds them until taken.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned Width = 4,
    parameter int unsigned CntW  = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [1:0]       In_Op,
    input  logic [Width-1:0] In_A,
    input  logic [Width-1:0] In_B,
    output logic [Width-1:0] First,
    output logic [Width-1:0] Second,
    output logic [1:0]       Op_Sel,
    input  logic [Width-1:0] Alu_Result,
    input  logic             Alu_Carry,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [Width-1:0] Out_Result,
    output logic             Out_Zero,
    output logic             Out_Carry,
    output logic [1:0]       Out_Op,
    output logic             Busy,
    output logic [CntW-1:0]  Done_Count
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_capture;
    logic             w_complete;
    logic             w_zero;
    logic             w_carry;

    logic [Width-1:0] r_first;
    logic [Width-1:0] r_second;
    logic [1:0]       r_op_sel;
    logic             r_out_valid;
    logic [Width-1:0] r_out_result;
    logic             r_out_zero;
    logic             r_out_carry;
    logic [1:0]       r_out_op;
    logic [CntW-1:0]  r_done_count;

    alu_flag_gen #(
        .Width (Width)
    ) u_flag_gen (
        .Alu_Result (Alu_Result),
        .Alu_Carry  (Alu_Carry),
        .Op_Sel     (r_op_sel),
        .Zero       (w_zero),
        .Carry      (w_carry)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (In_Valid) begin
                    w_load       = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_capture    = 1'b1;
                w_next_state = S_HOLD;
            end
            S_HOLD: begin
                if (r_out_valid && Out_Ready) begin
                    w_complete   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand and result registers only move on their strobes, so they hold between transactions.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_first      <= '0;
            r_second     <= '0;
            r_op_sel     <= OP_AND;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_carry  <= 1'b0;
            r_out_op     <= OP_AND;
            r_done_count <= '0;
        end else begin
            if (w_load) begin
                r_first  <= In_A;
                r_second <= In_B;
                r_op_sel <= In_Op;
            end
            if (w_capture) begin
                r_out_valid  <= 1'b1;
                r_out_result <= Alu_Result;
                r_out_zero   <= w_zero;
                r_out_carry  <= w_carry;
                r_out_op     <= r_op_sel;
            end
            if (w_complete) begin
                r_out_valid  <= 1'b0;
                r_done_count <= r_done_count + 1'b1;
            end
        end
    end

    assign In_Ready   = (r_state == S_IDLE);
    assign Busy       = (r_state != S_IDLE);
    assign First      = r_first;
    assign Second     = r_second;
    assign Op_Sel     = r_op_sel;
    assign Out_Valid  = r_out_valid;
    assign Out_Result = r_out_result;
    assign Out_Zero   = r_out_zero;
    assign Out_Carry  = r_out_carry;
    assign Out_Op     = r_out_op;
    assign Done_Count = r_done_count;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural ALU behind First/Second/Op_Sel.
module tb_alu_operand_sequencer;

    localparam int unsigned W = 4;
    localparam int unsigned C = 8;

    logic         Clock = 1'b0;
    logic         Reset_n = 1'b0;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [1:0]   In_Op = 2'd0;
    logic [W-1:0] In_A = '0;
    logic [W-1:0] In_B = '0;
    logic [W-1:0] First;
    logic [W-1:0] Second;
    logic [1:0]   Op_Sel;
    logic [W-1:0] Alu_Result;
    logic         Alu_Carry;
    logic         Out_Valid;
    logic         Out_Ready = 1'b1;
    logic [W-1:0] Out_Result;
    logic         Out_Zero;
    logic         Out_Carry;
    logic [1:0]   Out_Op;
    logic         Busy;
    logic [C-1:0] Done_Count;

    int checks = 0;
    int errors = 0;
    logic [C-1:0] exp_cnt = '0;

    alu_operand_sequencer #(
        .Width (W),
        .CntW  (C)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_Op      (In_Op),
        .In_A       (In_A),
        .In_B       (In_B),
        .First      (First),
        .Second     (Second),
        .Op_Sel     (Op_Sel),
        .Alu_Result (Alu_Result),
        .Alu_Carry  (Alu_Carry),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_Result (Out_Result),
        .Out_Zero   (Out_Zero),
        .Out_Carry  (Out_Carry),
        .Out_Op     (Out_Op),
        .Busy       (Busy),
        .Done_Count (Done_Count)
    );

    always #5 Clock = ~Clock;

    // External ALU: adder carry is always presented, the sequencer must mask it.
    logic [W:0] w_sum;
    always_comb begin
        w_sum     = {1'b0, First} + {1'b0, Second};
        Alu_Carry = w_sum[W];
        case (Op_Sel)
            2'd0:    Alu_Result = First & Second;
            2'd1:    Alu_Result = First | Second;
            2'd2:    Alu_Result = First ^ Second;
            default: Alu_Result = w_sum[W-1:0];
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a request at posedge+1, accepts at the next edge, checks capture one edge later.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] er, input logic ez, input logic ec);
        In_Valid = 1'b1; In_Op = op; In_A = a; In_B = b;
        chk("in_ready_idle", In_Ready, 1);
        @(posedge Clock); #1;
        In_Valid = 1'b0;
        chk("first", First, a);
        chk("second", Second, b);
        chk("op_sel", Op_Sel, op);
        chk("busy_issue", Busy, 1);
        chk("in_ready_issue", In_Ready, 0);
        chk("out_valid_issue", Out_Valid, 0);
        @(posedge Clock); #1;
        chk("out_valid", Out_Valid, 1);
        chk("out_result", Out_Result, er);
        chk("out_zero", Out_Zero, ez);
        chk("out_carry", Out_Carry, ec);
        chk("out_op", Out_Op, op);
    endtask

    task automatic finish_op(input logic [W-1:0] er);
        @(posedge Clock); #1;
        exp_cnt = exp_cnt + 1'b1;
        chk("out_valid_done", Out_Valid, 0);
        chk("done_count", Done_Count, exp_cnt);
        chk("busy_done", Busy, 0);
        chk("in_ready_done", In_Ready, 1);
        chk("result_held", Out_Result, er);
    endtask

    function automatic logic [W:0] ref_alu(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            2'd0:    return {1'b0, a & b};
            2'd1:    return {1'b0, a | b};
            2'd2:    return {1'b0, a ^ b};
            default: return s;
        endcase
    endfunction

    initial begin
        logic [W-1:0] a, b;
        logic [1:0]   op;
        logic [W:0]   r;

        #2;
        chk("rst_busy", Busy, 0);
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_first", First, 0);
        chk("rst_done", Done_Count, 0);
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        @(posedge Clock); #1;
        chk("in_ready_after_rst", In_Ready, 1);

        start_op(2'd1, 4'b1010, 4'b0101, 4'hF, 1'b0, 1'b0);
        finish_op(4'hF);
        start_op(2'd3, 4'hF, 4'h1, 4'h0, 1'b1, 1'b1);
        finish_op(4'h0);
        start_op(2'd2, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0);
        finish_op(4'h0);

        // Backpressure: AND C&A = 8, producer keeps offering a different request.
        Out_Ready = 1'b0;
        start_op(2'd0, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            In_Valid = 1'b1; In_Op = 2'd3; In_A = 4'h7; In_B = 4'h3;
            @(posedge Clock); #1;
            chk("bp_result", Out_Result, 4'h8);
            chk("bp_valid", Out_Valid, 1);
            chk("bp_in_ready", In_Ready, 0);
            chk("bp_first", First, 4'hC);
            chk("bp_done", Done_Count, exp_cnt);
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        finish_op(4'h8);

        // Reset while in ISSUE discards the in-flight ADD.
        In_Valid = 1'b1; In_Op = 2'd3; In_A = 4'h3; In_B = 4'h4;
        @(posedge Clock); #1;
        In_Valid = 1'b0;
        chk("pre_rst_busy", Busy, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("mr_busy", Busy, 0);
        chk("mr_first", First, 0);
        chk("mr_second", Second, 0);
        chk("mr_op_sel", Op_Sel, 0);
        chk("mr_out_valid", Out_Valid, 0);
        chk("mr_out_result", Out_Result, 0);
        chk("mr_out_zero", Out_Zero, 0);
        chk("mr_out_carry", Out_Carry, 0);
        chk("mr_out_op", Out_Op, 0);
        chk("mr_done", Done_Count, 0);
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        exp_cnt = '0;
        @(posedge Clock); #1;
        chk("mr_in_ready", In_Ready, 1);
        chk("mr_no_result", Out_Valid, 0);
        @(posedge Clock); #1;
        chk("mr_no_result2", Out_Valid, 0);
        chk("mr_idle", Busy, 0);

        // 256 back-to-back ADDs: Done_Count wraps to 0.
        for (int i = 0; i < 256; i++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            r = ref_alu(2'd3, a, b);
            start_op(2'd3, a, b, r[W-1:0], (r[W-1:0] == '0), r[W]);
            finish_op(r[W-1:0]);
        end
        chk("wrap_done", Done_Count, 0);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = W'($urandom_range(0, 15));
            b  = W'($urandom_range(0, 15));
            r  = ref_alu(op, a, b);
            start_op(op, a, b, r[W-1:0], (r[W-1:0] == '0), r[W]);
            finish_op(r[W-1:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
